// File: rtl/instruction_fetch_pkg.sv
// ----------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared definitions for the instruction fetch stage: the fetch FSM state
// encoding and the instruction / memory byte widths.
// ----------------------------------------------------------------------------
package instruction_fetch_pkg;

  localparam int INST_W      = 16;
  localparam int INST_BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LO_REQ  = 3'd1,
    S_LO_WAIT = 3'd2,
    S_HI_REQ  = 3'd3,
    S_HI_WAIT = 3'd4,
    S_VALID   = 3'd5,
    S_DRAIN   = 3'd6,
    S_FAULT   = 3'd7
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
// Fetches 16-bit instructions as two little-endian byte reads from a
// byte-wide, variable-latency instruction memory, starting at pc. The word is
// offered to the decoder with a valid/ready handshake; pc_advance pulses in
// the handshake cycle. flush aborts the fetch in progress and discards any
// memory response still owed.
//
// Optional feature (macro IFETCH_MISALIGN_CHECK_EN): an odd pc raises
// fetch_fault instead of issuing a request, held until flush. Without the
// macro odd addresses are fetched as given and fetch_fault is tied low.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   pc                  current program counter, used in S_LO_REQ
//   flush               abort current fetch, refetch from pc
//   mem_req/mem_addr    one-cycle read strobe and byte address
//   mem_rdata/rvalid    read byte and its valid strobe (one per request)
//   instr/instr_valid   assembled instruction {byte@addr+1, byte@addr}
//   instr_ready         decoder accepts instr
//   pc_advance          pulse in the handshake cycle
//   fetch_fault         misaligned-fetch fault
// ----------------------------------------------------------------------------
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int I_ADDR_W     = 12,
  parameter int INST_W_BYTES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [I_ADDR_W-1:0]    pc,
  input  logic                   flush,
  output logic                   mem_req,
  output logic [I_ADDR_W-1:0]    mem_addr,
  input  logic [INST_BYTE_W-1:0] mem_rdata,
  input  logic                   mem_rvalid,
  output logic [INST_W-1:0]      instr,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic                   pc_advance,
  output logic                   fetch_fault
);

  localparam logic [I_ADDR_W-1:0] ADDR_ONE = {{(I_ADDR_W-1){1'b0}}, 1'b1};

  if (INST_W_BYTES != 2) begin : g_bad_inst_bytes
    $error("instruction_fetch supports only INST_W_BYTES == 2");
  end

  fetch_state_e             state_q, state_d;
  logic [I_ADDR_W-1:0]      fetch_addr_q, fetch_addr_d;
  logic [INST_BYTE_W-1:0]   lo_byte_q, lo_byte_d;
  logic [INST_W-1:0]        instr_q, instr_d;
  logic                     instr_valid_q;
  logic                     mem_req_q;
  logic                     misalign_s;
  logic                     lo_req_s;

`ifdef IFETCH_MISALIGN_CHECK_EN
  assign misalign_s = pc[0];
`else
  assign misalign_s = 1'b0;
`endif

  assign lo_req_s = (state_q == S_LO_REQ);

  // mem_req_q marks the request states; a misaligned pc suppresses the
  // low-byte strobe. The low address comes straight from pc so that a pc
  // updated at the handshake edge is the one fetched next.
  assign mem_req     = mem_req_q & ~(lo_req_s & misalign_s);
  assign mem_addr    = !mem_req ? {I_ADDR_W{1'b0}} :
                       lo_req_s ? pc : (fetch_addr_q + ADDR_ONE);
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc_advance  = instr_valid_q & instr_ready & ~flush;

  // Next-state and datapath capture; flush outranks every other event.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    lo_byte_d    = lo_byte_q;
    instr_d      = instr_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_LO_REQ;
      end
      S_LO_REQ: begin
        if (misalign_s) begin
          // No request went out, so nothing is owed to drain.
          if (flush) begin
            state_d = S_LO_REQ;
          end else begin
            state_d = S_FAULT;
          end
        end else begin
          fetch_addr_d = pc;
          if (flush) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_LO_WAIT;
          end
        end
      end
      S_LO_WAIT: begin
        if (mem_rvalid) begin
          if (flush) begin
            state_d = S_LO_REQ;
          end else begin
            lo_byte_d = mem_rdata;
            state_d   = S_HI_REQ;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_LO_WAIT;
        end
      end
      S_HI_REQ: begin
        if (flush) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_HI_WAIT;
        end
      end
      S_HI_WAIT: begin
        if (mem_rvalid) begin
          if (flush) begin
            state_d = S_LO_REQ;
          end else begin
            instr_d = {mem_rdata, lo_byte_q};
            state_d = S_VALID;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_HI_WAIT;
        end
      end
      S_VALID: begin
        // Both a flush and a completed handshake restart at the current pc.
        if (flush || instr_ready) begin
          state_d = S_LO_REQ;
        end else begin
          state_d = S_VALID;
        end
      end
      S_DRAIN: begin
        // Further flushes are absorbed; only the owed response moves us on.
        if (mem_rvalid) begin
          state_d = S_LO_REQ;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_FAULT: begin
        if (flush) begin
          state_d = S_LO_REQ;
        end else begin
          state_d = S_FAULT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, address and byte-assembly registers plus registered output flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      fetch_addr_q  <= {I_ADDR_W{1'b0}};
      lo_byte_q     <= {INST_BYTE_W{1'b0}};
      instr_q       <= {INST_W{1'b0}};
      instr_valid_q <= 1'b0;
      mem_req_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_addr_q  <= fetch_addr_d;
      lo_byte_q     <= lo_byte_d;
      instr_q       <= instr_d;
      instr_valid_q <= (state_d == S_VALID);
      mem_req_q     <= (state_d == S_LO_REQ) || (state_d == S_HI_REQ);
    end
  end

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic fetch_fault_q;

  // Fault flag follows residency in S_FAULT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_fault_q <= 1'b0;
    end else begin
      fetch_fault_q <= (state_d == S_FAULT);
    end
  end

  assign fetch_fault = fetch_fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

endmodule
